mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that lets the pipelined core's instruction-fetch (IF) stage and data-access (MEM) stage share one single-ported, variable-latency memory. It captures one-cycle request pulses from each stage, serializes them onto the memory port using a handshake, returns read data with a one-cycle valid pulse, and drives a pipeline stall while any access is outstanding. Data accesses have priority over fetch. A bounded-burst guard guarantees that fetch is never starved.

## Interface
- ADDR_W, 10, memory address width (byte address)
- DATA_W, 64, memory data width
- MAX_D_BURST, 4, maximum consecutive data grants while a fetch is pending (1..15)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  one-cycle fetch request pulse
- if_addr  in  ADDR_W  fetch byte address, sampled with if_req
- if_rdata  out  32  fetched instruction: m_rdata[31:0] if if_addr[2]=0, else m_rdata[63:32]
- if_valid  out  1  one-cycle pulse, if_rdata valid
- d_req  in  1  one-cycle data request pulse
- d_we  in  1  1 = write, 0 = read, sampled with d_req
- d_addr  in  ADDR_W  data address, sampled with d_req
- d_wdata  in  DATA_W  write data, sampled with d_req
- d_rdata  out  DATA_W  read data
- d_valid  out  1  one-cycle completion pulse (reads and writes)
- m_req  out  1  memory request, held until accepted
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid when m_ready=1
- m_ready  in  1  memory completion; qualified by m_req
- stall  out  1  pipeline freeze

## Operation
- Per port, a pending flag and an operand register (addr, plus we/wdata for data). A req pulse sets the flag and loads the operands.
- A req pulse on a port that is already pending and not completing in that cycle is ignored: flag and operands unchanged.
- States:
  - IDLE: m_req=0.
  - D_BUSY and I_BUSY: m_req=1; m_addr, m_we and m_wdata driven from the granted port's operand register (m_we=0 in I_BUSY).
- Grant rule, evaluated in IDLE and at every completion edge over the pending flags as updated at that edge:
  - Data wins, unless dcount ≥ MAX_D_BURST and fetch is pending; then fetch wins.
  - Nothing pending → IDLE.
- dcount:
  - Increments on each data grant made while fetch is pending, saturating at 15.
  - Clears on any fetch grant, or when fetch is not pending.
- Completion: rising edge with m_req=1 and m_ready=1. That port's pending flag clears. The next grant is made at the same edge, so the next access issues back-to-back with no idle cycle.
- m_ready is ignored while m_req=0.
- Read data:
  - Data read completion registers m_rdata into d_rdata.
  - Data write completion leaves d_rdata unchanged; d_valid still pulses.
  - Fetch completion registers the selected half-word into if_rdata.
- stall = if_pend | d_pend | if_req | d_req (combinational). It is low in the cycle a valid pulse is high, unless another access is pending.

## Timing
- Reset (asynchronous assert, synchronous deassert at the next edge):
  - State IDLE; pending flags, dcount, m_req, m_we, if_valid and d_valid all 0.
  - if_rdata, d_rdata, m_addr and m_wdata all 0.
  - Reset mid-access drops m_req immediately and discards all pending requests.
- Minimum latency: req sampled at edge N, m_req=1 in cycle N+1; if m_ready=1 at edge N+1, valid is high in cycle N+2.
  - Read latency = 2 + (memory wait cycles).
- Request issued into an IDLE arbiter: m_* outputs are registered, so a req pulse at edge N is granted at edge N.
- m_addr, m_we and m_wdata stay stable while m_req=1 and m_ready=0.
- Simultaneous if_req and d_req at one edge: both flags set; data is granted.
- Req pulse on a port at that port's own completion edge: the set wins over the clear. The new request stays pending and is eligible in the same grant decision.
- Valid pulses are exactly one cycle. Two completions are never closer than one cycle apart.

## Test plan
- Single fetch, m_ready tied 1: if_req with if_addr=0x004, m_rdata=0xAAAA_BBBB_1111_2222 → m_addr=0x004 in cycle 1; if_valid in cycle 2 with if_rdata=0xAAAABBBB; stall high in cycles 0–1.
- Simultaneous requests: if_req (addr 0x010) and d_req read (addr 0x100) in one cycle, m_ready=1 → m_addr 0x100 then 0x010 in consecutive cycles; d_valid, then if_valid one cycle later.
- Wait states: data write addr 0x020, wdata 0x1234, m_ready low for 3 cycles → m_req/m_addr/m_wdata held for 4 cycles, m_we=1; d_valid one cycle after m_ready; d_rdata unchanged.
- Starvation guard, MAX_D_BURST=4: fetch pending, d_req re-pulsed at each d_valid → exactly 4 data grants, then the fetch grant, then data resumes.
- Duplicate request: second if_req with a different address while fetch is pending → ignored; the original address is served; exactly one if_valid.
- Reset mid-access: reset low while m_req=1 and the other port is pending → m_req, valid outputs and stall (once reqs are low) at 0 asynchronously; after release, no access issues without a new req.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the IF and MEM pipeline stages share one single-ported,
// variable-latency memory.
//
// Each port captures one-cycle request pulses into a pending flag plus operand
// registers. Pending requests are serialized onto the memory handshake (m_req held
// until m_ready). Read data comes back with a one-cycle valid pulse. Data accesses
// have priority over fetch, except that a burst guard hands the port to a waiting
// fetch after MAX_D_BURST consecutive data grants.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   if_req, if_addr            fetch request pulse and byte address
//   if_rdata, if_valid         selected 32-bit half of m_rdata, one-cycle valid pulse
//   d_req, d_we, d_addr,
//   d_wdata                    data request pulse and operands
//   d_rdata, d_valid           read data, one-cycle completion pulse (reads and writes)
//   m_req, m_we, m_addr,
//   m_wdata                    memory request, held until accepted (registered)
//   m_rdata, m_ready           memory read data and completion
//   stall                      pipeline freeze while any access is outstanding
//
// DATA_W is expected to be 64: fetch selects one 32-bit half of m_rdata.

module mem_arbiter #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              stall
);

    localparam logic [3:0] MaxBurst = 4'(MAX_D_BURST);

    typedef enum logic [1:0] {StIdle, StDBusy, StIBusy} state_e;

    state_e              state_q;
    logic                if_pend_q, d_pend_q;
    logic [ADDR_W-1:0]   if_addr_q, d_addr_q;
    logic                d_we_q;
    logic [DATA_W-1:0]   d_wdata_q;
    logic [3:0]          dcount_q;

    logic                complete, if_done, d_done, decide;
    logic                if_busy, d_busy, if_load, d_load;
    logic                if_pend_d, d_pend_d;
    logic [ADDR_W-1:0]   if_addr_d, d_addr_d;
    logic                d_we_d;
    logic [DATA_W-1:0]   d_wdata_d;
    logic                grant_i, grant_d;
    logic [3:0]          dcount_d;

    always_comb begin
        complete = m_req & m_ready;
        if_done  = complete & (state_q == StIBusy);
        d_done   = complete & (state_q == StDBusy);

        // A port still busy after this edge ignores a new pulse; at its own
        // completion edge a new pulse is accepted (set wins over clear).
        if_busy   = if_pend_q & ~if_done;
        d_busy    = d_pend_q & ~d_done;
        if_load   = if_req & ~if_busy;
        d_load    = d_req & ~d_busy;
        if_pend_d = if_busy | if_req;
        d_pend_d  = d_busy | d_req;

        if_addr_d = if_load ? if_addr : if_addr_q;
        d_addr_d  = d_load ? d_addr : d_addr_q;
        d_we_d    = d_load ? d_we : d_we_q;
        d_wdata_d = d_load ? d_wdata : d_wdata_q;

        // Grants are decided over the flags as updated at this edge.
        decide  = (state_q == StIdle) | complete;
        grant_i = decide & if_pend_d & (~d_pend_d | (dcount_q >= MaxBurst));
        grant_d = decide & d_pend_d & ~grant_i;

        dcount_d = dcount_q;
        if (!if_pend_d || grant_i) begin
            dcount_d = 4'd0;
        end else if (grant_d && dcount_q != 4'd15) begin
            dcount_d = dcount_q + 4'd1;
        end
    end

    assign stall = if_pend_q | d_pend_q | if_req | d_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            if_pend_q <= 1'b0;
            d_pend_q  <= 1'b0;
            if_addr_q <= '0;
            d_addr_q  <= '0;
            d_we_q    <= 1'b0;
            d_wdata_q <= '0;
            dcount_q  <= 4'd0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
        end else begin
            if_pend_q <= if_pend_d;
            d_pend_q  <= d_pend_d;
            if_addr_q <= if_addr_d;
            d_addr_q  <= d_addr_d;
            d_we_q    <= d_we_d;
            d_wdata_q <= d_wdata_d;
            dcount_q  <= dcount_d;

            if_valid <= if_done;
            d_valid  <= d_done;
            // Select on the address of the access being completed (old register value).
            if (if_done) begin
                if_rdata <= if_addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
            end
            if (d_done && !d_we_q) begin
                d_rdata <= m_rdata;
            end

            // m_* only change at a decision edge, so they hold through wait states.
            if (decide) begin
                if (grant_d) begin
                    state_q <= StDBusy;
                    m_req   <= 1'b1;
                    m_we    <= d_we_d;
                    m_addr  <= d_addr_d;
                    m_wdata <= d_wdata_d;
                end else if (grant_i) begin
                    state_q <= StIBusy;
                    m_req   <= 1'b1;
                    m_we    <= 1'b0;
                    m_addr  <= if_addr_d;
                end else begin
                    state_q <= StIdle;
                    m_req   <= 1'b0;
                    m_we    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters, MAX_D_BURST=4).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.

module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic              stall;

    int vectors     = 0;
    int miscompares = 0;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_D_BURST(4)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_rdata(if_rdata),
        .if_valid(if_valid),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_valid (d_valid),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        m_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_stall", stall, 0);
        reset = 1'b1;
        tick();
        check("idle_m_req", m_req, 0);

        // Single fetch, m_ready tied 1
        m_ready = 1'b1;
        m_rdata = 64'hAAAA_BBBB_1111_2222;
        if_req  = 1'b1;
        if_addr = 10'h004;
        #1;
        check("f_stall_c0", stall, 1);
        tick();
        if_req = 1'b0;
        check("f_m_req_c1", m_req, 1);
        check("f_m_addr_c1", m_addr, 10'h004);
        check("f_m_we_c1", m_we, 0);
        check("f_stall_c1", stall, 1);
        check("f_if_valid_c1", if_valid, 0);
        tick();
        check("f_if_valid_c2", if_valid, 1);
        check("f_if_rdata_c2", if_rdata, 32'hAAAA_BBBB);
        check("f_stall_c2", stall, 0);
        check("f_m_req_c2", m_req, 0);
        tick();
        check("f_if_valid_c3", if_valid, 0);

        // Simultaneous requests: data first, fetch back-to-back
        m_rdata = 64'h0123_4567_89AB_CDEF;
        if_req  = 1'b1;
        if_addr = 10'h010;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'h100;
        tick();
        if_req = 1'b0;
        d_req  = 1'b0;
        check("s_m_addr_c1", m_addr, 10'h100);
        check("s_m_req_c1", m_req, 1);
        tick();
        check("s_d_valid_c2", d_valid, 1);
        check("s_d_rdata_c2", d_rdata, 64'h0123_4567_89AB_CDEF);
        check("s_m_addr_c2", m_addr, 10'h010);
        check("s_m_req_c2", m_req, 1);
        check("s_if_valid_c2", if_valid, 0);
        check("s_stall_c2", stall, 1);
        tick();
        check("s_if_valid_c3", if_valid, 1);
        check("s_if_rdata_c3", if_rdata, 32'h89AB_CDEF);
        check("s_d_valid_c3", d_valid, 0);
        check("s_m_req_c3", m_req, 0);
        check("s_stall_c3", stall, 0);

        // Wait states on a data write
        m_ready = 1'b0;
        m_rdata = 64'hFFFF_0000_FFFF_0000;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h020;
        d_wdata = 64'h1234;
        tick();
        d_req   = 1'b0;
        d_addr  = 10'h3FF;
        d_wdata = 64'h9999;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m_ready = 1'b1;
            check($sformatf("w_m_req_%0d", i), m_req, 1);
            check($sformatf("w_m_addr_%0d", i), m_addr, 10'h020);
            check($sformatf("w_m_wdata_%0d", i), m_wdata, 64'h1234);
            check($sformatf("w_m_we_%0d", i), m_we, 1);
            check($sformatf("w_d_valid_%0d", i), d_valid, 0);
            tick();
        end
        check("w_d_valid", d_valid, 1);
        check("w_d_rdata_kept", d_rdata, 64'h0123_4567_89AB_CDEF);
        check("w_m_req_off", m_req, 0);
        tick();
        check("w_ready_ignored", d_valid, 0);
        check("w_idle_m_req", m_req, 0);

        // Starvation guard: 4 data grants, then fetch, then data resumes
        d_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if_req  = (k == 0);
            if_addr = 10'h040;
            d_req   = 1'b1;
            d_addr  = 10'(10'h200 + 8 * k);
            tick();
            if (k < 4) begin
                check($sformatf("b_m_addr_%0d", k), m_addr, 10'(10'h200 + 8 * k));
                check($sformatf("b_m_we_%0d", k), m_we, 0);
            end else begin
                check("b_m_addr_fetch", m_addr, 10'h040);
            end
            check($sformatf("b_if_valid_%0d", k), if_valid, 0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        check("b_if_valid", if_valid, 1);
        check("b_m_addr_resume", m_addr, 10'h220);
        check("b_m_req_resume", m_req, 1);
        tick();
        check("b_d_valid_last", d_valid, 1);
        check("b_m_req_end", m_req, 0);

        // Duplicate fetch request while pending is ignored
        m_ready = 1'b0;
        m_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        if_req  = 1'b1;
        if_addr = 10'h080;
        tick();
        if_addr = 10'h0C4;
        check("dup_m_addr_c1", m_addr, 10'h080);
        tick();
        if_req = 1'b0;
        check("dup_m_addr_c2", m_addr, 10'h080);
        m_ready = 1'b1;
        tick();
        check("dup_if_valid", if_valid, 1);
        check("dup_if_rdata", if_rdata, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("dup_no_second_%0d", i), if_valid, 0);
            check($sformatf("dup_m_req_%0d", i), m_req, 0);
        end

        // Reset mid-access with the other port pending
        m_ready = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h300;
        d_wdata = 64'h55;
        if_req  = 1'b1;
        if_addr = 10'h044;
        tick();
        d_req  = 1'b0;
        if_req = 1'b0;
        check("r_m_req_before", m_req, 1);
        check("r_stall_before", stall, 1);
        #2;
        reset = 1'b0;
        #1;
        check("r_m_req_async", m_req, 0);
        check("r_m_addr_async", m_addr, 0);
        check("r_stall_async", stall, 0);
        check("r_if_valid_async", if_valid, 0);
        check("r_d_valid_async", d_valid, 0);
        tick();
        reset   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("r_no_issue_%0d", i), m_req, 0);
            check($sformatf("r_stall_%0d", i), stall, 0);
            check($sformatf("r_valid_%0d", i), {if_valid, d_valid}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
